// File: rtl/ps2_key_history.sv
// ps2_key_history: PS/2 keyboard receiver with make-code history.
// Raw PS/2 clock/data are synchronised and deglitched, then deframed into
// bytes. Break (F0) and extended (E0) sequences are filtered out.
// The last four accepted make codes are kept on x, newest in x[7:0].
module ps2_key_history #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [31:0] x,
   output logic        key_valid,
   output logic [7:0]  key_code,
   output logic        parity_err,
   output logic        frame_err
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

   // Input conditioning state
   logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic          data_s1_q, data_s1_d, data_s2_q, data_s2_d;
   logic          clk_filt_q, clk_filt_d, clk_prev_q, clk_prev_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall;

   // Receive FSM state
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          byte_rdy_q, byte_rdy_d;
   logic          parity_err_q, parity_err_d;
   logic          frame_err_q, frame_err_d;

   // Decoder state
   logic [31:0]   x_q, x_d;
   logic [7:0]    held_q, held_d;
   logic [7:0]    key_code_q, key_code_d;
   logic          brk_q, brk_d, ext_q, ext_d;
   logic          key_valid_q, key_valid_d;

   // Synchronise both lines, then require FILTER_LEN agreeing samples before the clock level moves
   always_comb begin
      clk_s1_d   = ps2_clk;
      clk_s2_d   = clk_s1_q;
      data_s1_d  = ps2_data;
      data_s2_d  = data_s1_q;
      clk_filt_d = clk_filt_q;
      filt_cnt_d = '0;
      clk_prev_d = clk_filt_q;
      if (clk_s2_q != clk_filt_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            clk_filt_d = clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   assign fall = clk_prev_q & ~clk_filt_q;

   // Conditioning registers; the bus idles high so everything resets to 1
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
         clk_filt_q <= 1'b1;
         clk_prev_q <= 1'b1;
         filt_cnt_q <= '0;
      end else begin
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         data_s1_q  <= data_s1_d;
         data_s2_q  <= data_s2_d;
         clk_filt_q <= clk_filt_d;
         clk_prev_q <= clk_prev_d;
         filt_cnt_q <= filt_cnt_d;
      end
   end

   // Frame deframer: start, 8 data bits LSB-first, odd parity, stop; a stalled frame times out
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      to_cnt_d     = '0;
      byte_rdy_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      if (fall) begin
         case (state_q)
            ST_IDLE: begin
               if (!data_s2_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
            ST_DATA: begin
               shift_d = {data_s2_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
            ST_PARITY: begin
               parity_d = data_s2_q;
               state_d  = ST_STOP;
            end
            default: begin
               state_d = ST_IDLE;
               if (!data_s2_q) begin
                  frame_err_d = 1'b1;
               end else if (^{shift_q, parity_q}) begin
                  byte_rdy_d = 1'b1;
               end else begin
                  parity_err_d = 1'b1;
               end
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         if (to_cnt_q == TO_LAST) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end
   end

   // Receive FSM registers with registered status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         to_cnt_q     <= '0;
         byte_rdy_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         to_cnt_q     <= to_cnt_d;
         byte_rdy_q   <= byte_rdy_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Scan-code decoder: drop break/extended sequences and typematic repeats, push new make codes
   always_comb begin
      x_d         = x_q;
      held_d      = held_q;
      key_code_d  = key_code_q;
      brk_d       = brk_q;
      ext_d       = ext_q;
      key_valid_d = 1'b0;
      if (byte_rdy_q) begin
         if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (brk_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (shift_q == held_q) begin
               held_d = 8'h00;
            end
         end else if (ext_q) begin
            ext_d = 1'b0;
         end else if (shift_q != held_q) begin
            x_d         = {x_q[23:0], shift_q};
            held_d      = shift_q;
            key_code_d  = shift_q;
            key_valid_d = 1'b1;
         end
      end
   end

   // Decoder registers
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q         <= '0;
         held_q      <= 8'h00;
         key_code_q  <= 8'h00;
         brk_q       <= 1'b0;
         ext_q       <= 1'b0;
         key_valid_q <= 1'b0;
      end else begin
         x_q         <= x_d;
         held_q      <= held_d;
         key_code_q  <= key_code_d;
         brk_q       <= brk_d;
         ext_q       <= ext_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign x          = x_q;
   assign key_valid  = key_valid_q;
   assign key_code   = key_code_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;

endmodule

// File: doc/ps2_key_history.md
Name: ps2_key_history

Overview:
- Upstream stage of the note/seven-segment display path.
- Receives raw PS/2 keyboard clock/data, deframes scan-code bytes and filters out break and extended codes.
- Maintains a 32-bit history of the last four accepted make codes on `x`, newest in `x[7:0]`.
- `x` feeds the display decoder directly. Each byte lane holds either a raw set-2 make code or 0x00.

Parameters:
- FILTER_LEN, 8: consecutive identical `clk` samples needed before the filtered `ps2_clk` level changes.
- TIMEOUT_CYCLES, 100000: `clk` cycles without a filtered falling edge before an in-progress frame is aborted.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw keyboard clock, asynchronous
- ps2_data  in  1  raw keyboard data, asynchronous
- x  out  32  make-code history; `[7:0]` newest, `[31:24]` oldest
- key_valid  out  1  one-cycle pulse when a make code is pushed into `x`
- key_code  out  8  last pushed make code; holds its value between pulses
- parity_err  out  1  one-cycle pulse on a parity failure
- frame_err  out  1  one-cycle pulse on a bad stop bit or a timeout

Behaviour:
- Reset values:
  - `x`=0, `key_code`=0, `key_valid`=0, `parity_err`=0, `frame_err`=0.
  - Receive FSM in IDLE; bit counter and shift register = 0.
  - Filtered clock and synchroniser flops = 1 (bus idle high).
  - `held`=0x00, `brk`=0, `ext`=0, timeout counter = 0.
- Reset mid-frame discards the partial byte; the next start bit begins a fresh frame.
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
  - The filtered clock toggles only after FILTER_LEN consecutive samples differ from its current value.
  - `fall` = filtered clock was 1 last cycle and is 0 this cycle. `ps2_data` is sampled only on `fall`.
- Receive FSM, advancing only on `fall`:
  - IDLE: data=0 → DATA, bit count=0. Data=1 → stay in IDLE, no error.
  - DATA: shift the bit in LSB-first. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: always → IDLE.
    - Data=1 and odd parity over the 8 data bits plus parity bit is correct → `byte_rdy` for one cycle.
    - Data=0 → `frame_err` pulse; a bad stop bit takes priority over parity.
    - Stop=1 but parity wrong → `parity_err` pulse.
- Timeout:
  - The counter runs while the FSM is not in IDLE and clears on every `fall`.
  - When it reaches TIMEOUT_CYCLES: → IDLE, `frame_err` pulse, byte discarded.
- Byte decoder, acting on `byte_rdy`, in priority order:
  1. 0xF0: `brk`=1, no push.
  2. 0xE0: `ext`=1, no push.
  3. `brk`=1: `brk`=0 and `ext`=0. If the byte equals `held`, `held`=0x00. No push.
  4. `ext`=1: `ext`=0, no push (extended keys are ignored).
  5. Byte equals `held`: no push (suppresses typematic repeat).
  6. Otherwise push:
     - `x` ← {`x[23:0]`, byte}, `held` ← byte, `key_code` ← byte.
     - `key_valid`=1 for exactly one cycle.
- Latency: `byte_rdy` is registered in the cycle after the stop-bit `fall` is detected. `x`, `key_code` and `key_valid` update on the following edge, i.e. 2 cycles after stop-bit `fall` detection.
- Wrap-around: the 5th push drops the oldest code out of `x[31:24]`. There is no full condition.
- Simultaneous events: at most one byte completes per cycle, so there are no conflicts. Reset overrides everything.

Test Plan:
- Single key:
  - Stimulus: after reset, one valid frame 0x15 (Q).
  - Response: `key_valid` pulses once, `key_code`=0x15, `x`=0x00000015.
- Ordering and wrap:
  - Stimulus: frames 15,1D,24,2D,2C.
  - Response: five `key_valid` pulses, final `x`=0x1D242D2C.
- Break handling and typematic suppression:
  - Stimulus: 15,15,15 (held), then F0,15, then 15.
  - Response: exactly two pushes; `x`=0x00001515 at the end; no push for the F0 sequence.
- Extended codes:
  - Stimulus: E0,75 then F0,E0... sequences, then 1C.
  - Response: only 1C pushed; `x`=0x0000001C.
- Errors:
  - Stimulus 1: frame 0x24 with wrong parity. Response: `parity_err` pulse, `x` unchanged.
  - Stimulus 2: frame with stop=0. Response: `frame_err` pulse.
  - Stimulus 3: 5 bits then `ps2_clk` held high for TIMEOUT_CYCLES. Response: `frame_err` pulse; a following valid 0x1B frame is accepted (`x[7:0]`=0x1B).
- Reset mid-frame:
  - Stimulus: assert `rst` after 4 data bits, deassert, send full frame 0x3A.
  - Response: all outputs 0 during reset, then `x`=0x0000003A.
